// File: rtl/simon_datapath_if.sv
// Bundles the datapath's control inputs and status outputs. The controller
// FSM uses the master side and the datapath uses the slave side.
interface simon_datapath_if;
  logic       level;
  logic [3:0] pattern;
  logic       srld;
  logic       scld;
  logic       rcld;
  logic       rcclr;
  logic       led_sel;
  logic       is_legal;
  logic       correct_pattern;
  logic       is_last_element;
  logic       store_full;
  logic [3:0] pattern_leds;

  modport master (
    output level, pattern, srld, scld, rcld, rcclr, led_sel,
    input  is_legal, correct_pattern, is_last_element, store_full, pattern_leds
  );

  modport slave (
    input  level, pattern, srld, scld, rcld, rcclr, led_sel,
    output is_legal, correct_pattern, is_last_element, store_full, pattern_leds
  );
endinterface

// File: rtl/simon_datapath.sv
// Simon game datapath: a 64-entry pattern store with write/read counters,
// a difficulty latch frozen after the first store, and combinational status.
module simon_datapath (
  input  logic              clk,
  input  logic              rst,
  simon_datapath_if.slave   bus
);

  localparam int unsigned Depth = 64;

  logic [3:0] store_q [Depth];
  logic [6:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic       lvl_q, lvl_d;
  logic       full;
  logic       wr_en;
  logic [3:0] rd_entry;

  // wr_cnt never exceeds 64, so bit 6 alone marks a full store.
  assign full     = wr_cnt_q[6];
  // An edge that coincides with reset must not disturb the store either.
  assign wr_en    = bus.srld & ~full & rst;
  assign rd_entry = store_q[rd_cnt_q];

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (bus.scld && !full) begin
      wr_cnt_d = wr_cnt_q + 7'd1;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (bus.rcclr) begin
      rd_cnt_d = 6'd0;
    end else if (bus.rcld && (rd_cnt_q != 6'd63)) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    if (wr_cnt_q == 7'd0) begin
      lvl_d = bus.level;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q <= 7'd0;
      rd_cnt_q <= 6'd0;
      lvl_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      store_q[wr_cnt_q[5:0]] <= bus.pattern;
    end
  end

  always_comb begin
    bus.store_full      = full;
    bus.correct_pattern = (bus.pattern == rd_entry);
    bus.is_last_element = (wr_cnt_q != 7'd0) && ({1'b0, rd_cnt_q} == (wr_cnt_q - 7'd1));
    bus.pattern_leds    = bus.led_sel ? bus.pattern : rd_entry;
    if (lvl_q) begin
      bus.is_legal = (bus.pattern != 4'd0);
    end else begin
      bus.is_legal = (bus.pattern != 4'd0) && ((bus.pattern & (bus.pattern - 4'd1)) == 4'd0);
    end
  end

endmodule
